// File: rtl/mpu_load_stream.sv
// mpu_load_stream: streaming matrix loader, one element per cycle into the MPU register file.
//
// Purpose
//   Accepts a load command (size, destination register, optional transpose),
//   then moves m*n elements from a valid/ready source stream into register-file
//   writes that hold until the register file accepts them. Supports abort.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   req                   : command strobe, sampled only while idle
//   matrix_m_size/n_size  : source rows / columns
//   load_addr             : destination matrix register
//   transpose             : store the transposed source matrix
//   abort                 : cancel the load in progress
//   ack                   : one-cycle pulse, command accepted
//   error                 : dimension error, sticky until the next req
//   busy                  : load in progress
//   done                  : one-cycle pulse after the last write completes
//   in_valid/in_element   : source stream
//   in_ready              : loader can take an element
//   reg_write_en          : register-file write valid (held until reg_ready)
//   reg_ready             : register file accepts the write
//   reg_load_addr         : latched destination register
//   reg_element_out       : element data
//   reg_m_out/reg_n_out   : destination row / column index
//   reg_m_size/reg_n_size : destination dimensions (swapped when transposed)

module mpu_load_stream #(
    parameter int FP            = 32,
    parameter int M_MAX         = 4,
    parameter int N_MAX         = 4,
    parameter int MBITS         = $clog2(M_MAX),
    parameter int NBITS         = $clog2(N_MAX),
    parameter int REG_ADDR_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req,
    input  logic [MBITS:0]           matrix_m_size,
    input  logic [NBITS:0]           matrix_n_size,
    input  logic [REG_ADDR_BITS-1:0] load_addr,
    input  logic                     transpose,
    input  logic                     abort,
    output logic                     ack,
    output logic                     error,
    output logic                     busy,
    output logic                     done,

    input  logic                     in_valid,
    input  logic [FP-1:0]            in_element,
    output logic                     in_ready,

    output logic                     reg_write_en,
    input  logic                     reg_ready,
    output logic [REG_ADDR_BITS-1:0] reg_load_addr,
    output logic [FP-1:0]            reg_element_out,
    output logic [MBITS:0]           reg_m_out,
    output logic [NBITS:0]           reg_n_out,
    output logic [MBITS:0]           reg_m_size,
    output logic [NBITS:0]           reg_n_size
);

    // Common width able to hold either size port, for the legality compares.
    localparam int SW    = ((MBITS > NBITS) ? MBITS : NBITS) + 1;
    // Element counter covers 0 .. M_MAX*N_MAX.
    localparam int CBITS = $clog2(M_MAX * N_MAX + 1);

    localparam logic [MBITS:0]   ONE_M = (MBITS + 1)'(1);
    localparam logic [NBITS:0]   ONE_N = (NBITS + 1)'(1);
    localparam logic [CBITS-1:0] ONE_C = CBITS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN
    } state_t;

    state_t            r_state;
    logic [NBITS:0]    r_n;
    logic              r_tr;
    logic [CBITS-1:0]  r_last;
    logic [CBITS-1:0]  r_cnt;
    logic [MBITS:0]    r_row;
    logic [NBITS:0]    r_col;

    logic [SW-1:0]     w_m;
    logic [SW-1:0]     w_n;
    logic              w_dims_ok;
    logic              w_xfer;
    logic              w_last;
    logic              w_col_wrap;

    assign w_m = SW'(matrix_m_size);
    assign w_n = SW'(matrix_n_size);

    // A transposed load must also fit the swapped destination shape.
    assign w_dims_ok = (w_m != '0) && (w_n != '0)
                    && (w_m <= SW'(M_MAX)) && (w_n <= SW'(N_MAX))
                    && (!transpose
                        || ((w_m <= SW'(N_MAX)) && (w_n <= SW'(M_MAX))));

    // The ack cycle is kept closed so the first element is taken one
    // cycle after the acceptance pulse. A pending write that completes
    // this cycle frees the output stage for a new element.
    assign in_ready = (r_state == S_LOAD) && !ack
                   && (!reg_write_en || reg_ready);

    assign w_xfer     = in_valid && in_ready;
    assign w_last     = (r_cnt == r_last);
    assign w_col_wrap = ((r_col + ONE_N) == r_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            ack             <= 1'b0;
            error           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            reg_write_en    <= 1'b0;
            reg_load_addr   <= '0;
            reg_element_out <= '0;
            reg_m_out       <= '0;
            reg_n_out       <= '0;
            reg_m_size      <= '0;
            reg_n_size      <= '0;
            r_n             <= '0;
            r_tr            <= 1'b0;
            r_last          <= '0;
            r_cnt           <= '0;
            r_row           <= '0;
            r_col           <= '0;
        end else begin
            ack  <= 1'b0;
            done <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (req) begin
                        if (w_dims_ok) begin
                            error         <= 1'b0;
                            ack           <= 1'b1;
                            busy          <= 1'b1;
                            r_n           <= matrix_n_size;
                            r_tr          <= transpose;
                            r_last        <= CBITS'(matrix_m_size)
                                           * CBITS'(matrix_n_size) - ONE_C;
                            r_cnt         <= '0;
                            r_row         <= '0;
                            r_col         <= '0;
                            reg_load_addr <= load_addr;
                            reg_m_size    <= transpose
                                           ? (MBITS + 1)'(matrix_n_size)
                                           : matrix_m_size;
                            reg_n_size    <= transpose
                                           ? (NBITS + 1)'(matrix_m_size)
                                           : matrix_n_size;
                            r_state       <= S_LOAD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (abort) begin
                        r_state      <= S_IDLE;
                        busy         <= 1'b0;
                        reg_write_en <= 1'b0;
                    end else if (w_xfer) begin
                        reg_write_en    <= 1'b1;
                        reg_element_out <= in_element;
                        // Source is row-major; a transposed store swaps
                        // the destination row and column.
                        reg_m_out       <= r_tr ? (MBITS + 1)'(r_col)
                                                : r_row;
                        reg_n_out       <= r_tr ? (NBITS + 1)'(r_row)
                                                : r_col;
                        r_cnt           <= r_cnt + ONE_C;
                        if (w_col_wrap) begin
                            r_col <= '0;
                            r_row <= r_row + ONE_M;
                        end else begin
                            r_col <= r_col + ONE_N;
                        end
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end else if (reg_ready) begin
                        reg_write_en <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (abort) begin
                        r_state      <= S_IDLE;
                        busy         <= 1'b0;
                        reg_write_en <= 1'b0;
                    end else if (reg_write_en && reg_ready) begin
                        reg_write_en <= 1'b0;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_load_stream.sv
// tb_mpu_load_stream: directed bench for mpu_load_stream.
// Expected register-file writes are queued as elements are accepted.

module tb_mpu_load_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  matrix_m_size = '0;
    logic [2:0]  matrix_n_size = '0;
    logic [2:0]  load_addr = '0;
    logic        transpose = 1'b0;
    logic        abort = 1'b0;
    logic        ack;
    logic        error;
    logic        busy;
    logic        done;
    logic        in_valid = 1'b0;
    logic [31:0] in_element = '0;
    logic        in_ready;
    logic        reg_write_en;
    logic        reg_ready = 1'b1;
    logic [2:0]  reg_load_addr;
    logic [31:0] reg_element_out;
    logic [2:0]  reg_m_out;
    logic [2:0]  reg_n_out;
    logic [2:0]  reg_m_size;
    logic [2:0]  reg_n_size;

    mpu_load_stream #(
        .FP(32), .M_MAX(4), .N_MAX(4), .REG_ADDR_BITS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .matrix_m_size(matrix_m_size),
        .matrix_n_size(matrix_n_size),
        .load_addr(load_addr),
        .transpose(transpose),
        .abort(abort),
        .ack(ack),
        .error(error),
        .busy(busy),
        .done(done),
        .in_valid(in_valid),
        .in_element(in_element),
        .in_ready(in_ready),
        .reg_write_en(reg_write_en),
        .reg_ready(reg_ready),
        .reg_load_addr(reg_load_addr),
        .reg_element_out(reg_element_out),
        .reg_m_out(reg_m_out),
        .reg_n_out(reg_n_out),
        .reg_m_size(reg_m_size),
        .reg_n_size(reg_n_size)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  a;
        logic [2:0]  m;
        logic [2:0]  n;
        logic [31:0] d;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_writes = 0;
    int          last_wr_cyc = -10;
    wr_t         sb[$];
    logic [31:0] elem[16];
    logic        hold = 1'b0;
    wr_t         held;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: scoreboard pop on every completed write, plus a
    // stability check on every stalled cycle.
    always @(negedge clk) begin : mon
        wr_t cur;
        cur = {reg_load_addr, reg_m_out, reg_n_out, reg_element_out};
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold)
                chk("stall_hold", {reg_write_en, cur}, {1'b1, held});
            if (reg_write_en && reg_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL write_unexpected observed=%0h expected=none",
                           cur);
                end else begin
                    chk("write", cur, sb.pop_front());
                end
                n_writes++;
                last_wr_cyc = cyc;
            end
            hold = reg_write_en && !reg_ready;
            held = cur;
        end
    end

    function automatic wr_t exp_wr(input int k, input int n,
                                   input int addr, input bit tr);
        wr_t e;
        int r, c;
        r = k / n;
        c = k % n;
        e.a = 3'(addr);
        e.m = tr ? 3'(c) : 3'(r);
        e.n = tr ? 3'(r) : 3'(c);
        e.d = elem[k];
        return e;
    endfunction

    task automatic issue(input int m, input int n, input int addr,
                         input bit tr);
        @(posedge clk); #1;
        req = 1'b1;
        matrix_m_size = 3'(m);
        matrix_n_size = 3'(n);
        load_addr = 3'(addr);
        transpose = tr;
        @(posedge clk); #1;
        req = 1'b0;
        transpose = 1'b0;
    endtask

    task automatic do_load(input int m, input int n, input int addr,
                           input bit tr, input int gap_pct,
                           input int stall_pct);
        int k, total, base, c, cdone;
        bit seen;
        total = m * n;
        base = n_writes;
        k = 0;
        c = 0;
        cdone = 0;
        seen = 1'b0;
        issue(m, n, addr, tr);
        @(negedge clk);
        chk("ack", ack, 1);
        chk("busy_rise", busy, 1);
        chk("error_clr", error, 0);
        chk("in_ready_ack", in_ready, 0);
        chk("dst_size", {reg_m_size, reg_n_size},
            tr ? {3'(n), 3'(m)} : {3'(m), 3'(n)});
        chk("dst_addr", reg_load_addr, addr);
        while (c < 400 && !seen) begin
            @(posedge clk); #1;
            in_valid = (k < total) && ($urandom_range(99) >= gap_pct);
            in_element = (k < total) ? elem[k] : 32'h0;
            reg_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(exp_wr(k, n, addr, tr));
                k++;
            end
            if (done) begin
                seen = 1'b1;
                cdone = cyc;
            end
            c++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        reg_ready = 1'b1;
        chk("done_seen", seen, 1);
        chk("write_count", n_writes - base, total);
        chk("done_latency", cdone, last_wr_cyc + 1);
        chk("sb_drained", sb.size(), 0);
        @(negedge clk);
        chk("busy_fall", busy, 0);
        chk("done_pulse", done, 0);
    endtask

    task automatic bad_req(input string tag, input int m, input int n,
                           input bit tr);
        int base;
        base = n_writes;
        issue(m, n, 1, tr);
        in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_error"}, error, 1);
        chk({tag, "_noack"}, ack, 0);
        chk({tag, "_nobusy"}, busy, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_sticky"}, error, 1);
        chk({tag, "_noready"}, in_ready, 0);
        chk({tag, "_nowrite"}, n_writes - base, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        int k, base, g;
        bit dseen;

        // Reset values
        #12;
        chk("rst_ack", ack, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_reg_we", reg_write_en, 0);
        chk("rst_reg_bus", {reg_load_addr, reg_element_out, reg_m_out,
                            reg_n_out, reg_m_size, reg_n_size}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Legal 2x3 row-major load of 1.0 .. 6.0
        elem[0] = 32'h3F800000;
        elem[1] = 32'h40000000;
        elem[2] = 32'h40400000;
        elem[3] = 32'h40800000;
        elem[4] = 32'h40A00000;
        elem[5] = 32'h40C00000;
        do_load(2, 3, 5, 1'b0, 0, 0);

        // Transposed 2x3
        do_load(2, 3, 1, 1'b1, 0, 0);

        // Dimension errors, then a legal req clears error
        bad_req("m_zero", 0, 3, 1'b0);
        bad_req("n_big", 2, 5, 1'b0);
        bad_req("tr_m_big", 5, 2, 1'b1);
        for (int i = 0; i < 16; i++) elem[i] = $urandom;
        do_load(1, 4, 3, 1'b0, 0, 0);

        // Backpressure on both sides
        for (int i = 0; i < 16; i++) elem[i] = $urandom;
        do_load(4, 4, 6, 1'b0, 30, 45);
        for (int i = 0; i < 16; i++) elem[i] = $urandom;
        do_load(3, 4, 4, 1'b1, 20, 30);

        // Abort after the third transfer of a 4x4 load
        for (int i = 0; i < 16; i++) elem[i] = $urandom;
        base = n_writes;
        issue(4, 4, 2, 1'b0);
        @(negedge clk);
        chk("abort_ack", ack, 1);
        k = 0;
        g = 0;
        while (k < 3 && g < 50) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_element = elem[k];
            reg_ready = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(exp_wr(k, 4, 2, 1'b0));
                k++;
            end
            g++;
        end
        @(posedge clk); #1;
        abort = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b1;
        in_element = elem[3];
        @(negedge clk);
        dseen = done;
        chk("abort_busy", busy, 0);
        chk("abort_we", reg_write_en, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (8) begin
            @(negedge clk);
            if (done) dseen = 1'b1;
        end
        in_valid = 1'b0;
        chk("abort_no_done", dseen, 0);
        chk("abort_writes", n_writes - base, 3);
        chk("abort_sb", sb.size(), 0);
        for (int i = 0; i < 16; i++) elem[i] = $urandom;
        do_load(2, 2, 7, 1'b0, 10, 30);

        // Asynchronous reset in the middle of a load
        for (int i = 0; i < 16; i++) elem[i] = $urandom;
        issue(4, 4, 7, 1'b0);
        k = 0;
        repeat (5) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_element = elem[k];
            reg_ready = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(exp_wr(k, 4, 7, 1'b0));
                k++;
            end
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        sb.delete();
        chk("arst_busy", busy, 0);
        chk("arst_we", reg_write_en, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_pulses", {ack, done, error}, 0);
        chk("arst_reg_bus", {reg_load_addr, reg_element_out, reg_m_out,
                             reg_n_out, reg_m_size, reg_n_size}, 0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) elem[i] = $urandom;
        do_load(2, 2, 3, 1'b0, 0, 0);

        chk("final_sb", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
